router_reg: RTL and testbench
=============================

// Module: router_reg
// PURPOSE
//  Datapath/register stage of the 1x3 router, directly downstream of router_fsm: registers header and
//  payload bytes, holds a byte across FIFO-full stalls, accumulates/checks packet parity, returns
//  parity_done/low_pkt_valid to the FSM and drives dout into the selected output FIFO.
// PARAMETERS
//  DATA_W  8  byte width; header = {payload_len[DATA_W-1:2], addr[1:0]}
// PORTS
//  clock          in   1       rising-edge clock
//  reset          in   1       synchronous, active-high reset
//  pkt_valid      in   1       source byte valid; falls with the parity byte on data_in
//  data_in        in   DATA_W  source byte: header, payload or parity
//  fifo_full      in   1       full flag of the selected FIFO
//  detect_add     in   1       FSM DECODE_ADDRESS state
//  lfd_state      in   1       FSM LOAD_FIRST_DATA state
//  ld_state       in   1       FSM LOAD_DATA state
//  laf_state      in   1       FSM LOAD_AFTER_FULL state
//  full_state     in   1       FSM FIFO_FULL_STATE
//  rst_int_reg    in   1       FSM CHECK_PARITY_ERROR state; clears low_pkt_valid
//  parity_done    out  1       parity byte captured
//  low_pkt_valid  out  1       pkt_valid seen low during ld_state
//  err            out  1       parity mismatch for the current packet
//  dout           out  DATA_W  byte to FIFO
// BEHAVIOUR
//  - All outputs/internal registers update on rising clock; each effect is visible 1 cycle after its
//    sampled condition. Reset: dout=0, parity_done=0, low_pkt_valid=0, err=0, hdr/hold/int_par/pkt_par=0.
//    reset wins over every other condition, including mid-packet.
//  - hdr <= data_in when detect_add & pkt_valid & data_in[1:0]!=2'b11; int_par <= 0,
//    parity_done <= 0, err <= 0 when detect_add.
//  - dout priority: lfd_state -> hdr; ld_state & !fifo_full -> data_in; laf_state -> hold; else hold value.
//  - hold <= data_in when ld_state & fifo_full (byte not lost across stall).
//  - int_par ^= hdr when lfd_state; int_par ^= data_in when ld_state & pkt_valid & !fifo_full & !full_state;
//    in laf_state int_par ^= hold if hold was a payload byte (pkt_valid high at capture).
//  - pkt_par <= data_in and parity_done <= 1 when (ld_state & !fifo_full & !pkt_valid) or
//    (laf_state & low_pkt_valid & !parity_done); parity byte in hold is used in the laf case.
//  - low_pkt_valid <= 1 when ld_state & !pkt_valid; <= 0 when rst_int_reg (clear wins if both).
//  - err <= (int_par != pkt_par) on the cycle after parity_done rises; held until next detect_add.
//  - Simultaneous fifo_full and last byte in ld_state: byte goes to hold, parity_done deferred to laf.
// CONFIGURATION
//  ROUTER_REG_LEN_CHECK_EN defined: adds output len_err (1 bit, reset 0); payload byte counter
//    (DATA_W-2 bits, saturating) cleared on detect_add; at parity_done len_err <= (count != hdr[DATA_W-1:2]);
//    cleared on detect_add. Undefined: no counter, no len_err port.
// STRUCTURE
//  - Shared package router_pkg: DATA_W default, ADDR_INVALID=2'b11, header field slice localparams.
//  - Sub-module router_parity_acc: int_par accumulator with clear/xor-enable/compare -> mismatch.
//  - Top holds hdr/hold/dout muxing and the parity_done/low_pkt_valid flags.
// TESTING
//  1 reset asserted mid-payload -> next cycle all outputs 0; following packet processes cleanly.
//  2 header 8'h0D, payload A1,B2,C3, parity DD, no full -> dout 0D,A1,B2,C3; parity_done=1; err=0.
//  3 same packet, parity DC -> err=1 one cycle after parity_done; cleared on next detect_add.
//  4 fifo_full during B2 in ld_state -> hold=B2; laf_state drives dout=B2; final err=0.
//  5 full on parity byte -> parity_done rises only in laf_state; low_pkt_valid clears on rst_int_reg.
//  6 ROUTER_REG_LEN_CHECK_EN: header 8'h11 (len 4) with 3 payload bytes -> len_err=1; len 3 -> 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router datapath: byte width default, header field layout,
// and the parity-accumulator source select.
package router_pkg;

  localparam int unsigned DEF_DATA_W = 8;

  // Header byte layout: {payload_len, addr}
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned LEN_LSB = ADDR_W;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  // Which byte, if any, is folded into the running parity this cycle
  typedef enum logic [1:0] {
    PAR_SRC_NONE = 2'd0,
    PAR_SRC_HDR  = 2'd1,
    PAR_SRC_DATA = 2'd2,
    PAR_SRC_HOLD = 2'd3
  } par_src_e;

  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR of header and payload bytes for the current packet, compared against the
// captured parity byte.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              xor_en,
  input  logic [DATA_W-1:0] xor_data,
  input  logic [DATA_W-1:0] ref_par,
  output logic [DATA_W-1:0] int_par,
  output logic              mismatch_c
);

  always_ff @(posedge clock) begin
    if (reset) begin
      int_par <= '0;
    end else if (clr) begin
      int_par <= '0;
    end else if (xor_en) begin
      int_par <= int_par ^ xor_data;
    end
  end

  assign mismatch_c = (int_par != ref_par);

endmodule

// File: rtl/router_reg.sv
// Router register stage: header/hold/dout registers, parity capture and check, FSM status flags.
// Optional payload length check enabled by defining ROUTER_REG_LEN_CHECK_EN (adds len_err).
module router_reg
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic [DATA_W-1:0] dout
`ifdef ROUTER_REG_LEN_CHECK_EN
  ,
  output logic              len_err
`endif
);

  logic [DATA_W-1:0] hdr;
  logic [DATA_W-1:0] hold;
  logic              hold_payload;
  logic [DATA_W-1:0] pkt_par;
  logic              parity_done_q;

  par_src_e          par_src;
  logic              par_xor_en;
  logic [DATA_W-1:0] par_xor_data;
  logic              par_from_data;
  logic              par_from_hold;
  logic              par_set;
  logic [DATA_W-1:0] par_byte;
  logic              hdr_load;
  logic              parity_rise;
  logic [DATA_W-1:0] int_par;
  logic              mismatch_c;

  // Parity source select and parity-byte capture conditions
  always_comb begin
    par_src      = PAR_SRC_NONE;
    par_xor_data = '0;
    if (lfd_state) begin
      par_src = PAR_SRC_HDR;
    end else if (ld_state && pkt_valid && !fifo_full && !full_state) begin
      par_src = PAR_SRC_DATA;
    end else if (laf_state && hold_payload) begin
      par_src = PAR_SRC_HOLD;
    end

    case (par_src)
      PAR_SRC_HDR:  par_xor_data = hdr;
      PAR_SRC_DATA: par_xor_data = data_in;
      PAR_SRC_HOLD: par_xor_data = hold;
      default:      par_xor_data = '0;
    endcase
    par_xor_en = (par_src != PAR_SRC_NONE);

    par_from_data = ld_state && !fifo_full && !pkt_valid;
    par_from_hold = laf_state && low_pkt_valid && !parity_done;
    par_set       = par_from_data || par_from_hold;
    par_byte      = par_from_data ? data_in : hold;

    hdr_load    = detect_add && pkt_valid && addr_valid(data_in[ADDR_W-1:0]);
    parity_rise = parity_done && !parity_done_q;
  end

  router_parity_acc #(
    .DATA_W(DATA_W)
  ) u_parity_acc (
    .clock     (clock),
    .reset     (reset),
    .clr       (detect_add),
    .xor_en    (par_xor_en),
    .xor_data  (par_xor_data),
    .ref_par   (pkt_par),
    .int_par   (int_par),
    .mismatch_c(mismatch_c)
  );

  // Header, stall hold register and FIFO write data
  always_ff @(posedge clock) begin
    if (reset) begin
      hdr          <= '0;
      hold         <= '0;
      hold_payload <= 1'b0;
      dout         <= '0;
    end else begin
      if (hdr_load) begin
        hdr <= data_in;
      end
      // A byte presented while the FIFO is full is parked until LOAD_AFTER_FULL
      if (ld_state && fifo_full) begin
        hold         <= data_in;
        hold_payload <= pkt_valid;
      end
      if (lfd_state) begin
        dout <= hdr;
      end else if (ld_state && !fifo_full) begin
        dout <= data_in;
      end else if (laf_state) begin
        dout <= hold;
      end
    end
  end

  // Parity capture, status flags and error
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_par       <= '0;
      parity_done   <= 1'b0;
      parity_done_q <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
    end else begin
      parity_done_q <= parity_done;
      if (par_set) begin
        pkt_par <= par_byte;
      end

      if (detect_add) begin
        parity_done <= 1'b0;
      end else if (par_set) begin
        parity_done <= 1'b1;
      end

      if (rst_int_reg) begin
        low_pkt_valid <= 1'b0;
      end else if (ld_state && !pkt_valid) begin
        low_pkt_valid <= 1'b1;
      end

      // int_par is final by the cycle after the parity byte lands
      if (detect_add) begin
        err <= 1'b0;
      end else if (parity_rise) begin
        err <= mismatch_c;
      end
    end
  end

`ifdef ROUTER_REG_LEN_CHECK_EN
  localparam int unsigned LEN_W = DATA_W - LEN_LSB;

  logic [LEN_W-1:0] len_cnt;

  // Saturating count of payload bytes folded into parity
  always_ff @(posedge clock) begin
    if (reset) begin
      len_cnt <= '0;
      len_err <= 1'b0;
    end else begin
      if (detect_add) begin
        len_cnt <= '0;
      end else if ((par_src == PAR_SRC_DATA || par_src == PAR_SRC_HOLD) && (len_cnt != '1)) begin
        len_cnt <= len_cnt + LEN_W'(1);
      end

      if (detect_add) begin
        len_err <= 1'b0;
      end else if (par_set) begin
        len_err <= (len_cnt != hdr[DATA_W-1:LEN_LSB]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: drives router_fsm-like state sequences and checks
// against packet-level expectations.
`timescale 1ns/1ps
module tb_router_reg;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;
  logic [7:0] dout;
`ifdef ROUTER_REG_LEN_CHECK_EN
  logic       len_err;
`endif

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] pay [0:63];
  logic [7:0] last_hdr;

  router_reg dut (
    .clock        (clock),
    .reset        (reset),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err),
    .dout         (dout)
`ifdef ROUTER_REG_LEN_CHECK_EN
    ,
    .len_err      (len_err)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pkt_valid   = 1'b0;
    data_in     = 8'($urandom);
    fifo_full   = 1'b0;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
  endtask

  task automatic stall(input int cycles, input logic pv);
    for (int c = 0; c < cycles; c++) begin
      idle_inputs();
      full_state = 1'b1;
      fifo_full  = 1'b1;
      pkt_valid  = pv;
      tick();
    end
  endtask

  // One full packet as router_fsm would sequence it; pay[0:n-1] holds the payload
  task automatic send_packet(input logic [7:0] h, input int n, input logic [7:0] par,
                             input int full_idx, input bit full_par, input int stall_cyc,
                             input bit exp_err, input bit exp_len_err);
    logic [7:0] prev;
    idle_inputs(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = h; tick();
    n_cmp++;
    if (err !== 1'b0 || parity_done !== 1'b0) begin
      n_mis++; $display("FAIL decode_clear: err=%b parity_done=%b want 0 0", err, parity_done);
    end
    last_hdr = h;
    idle_inputs(); lfd_state = 1'b1; pkt_valid = 1'b1; data_in = h; tick();
    n_cmp++;
    if (dout !== h) begin n_mis++; $display("FAIL lfd_dout: got %h want %h", dout, h); end
    prev = h;
    for (int i = 0; i < n; i++) begin
      idle_inputs(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = pay[i];
      fifo_full = (i == full_idx); tick();
      if (i == full_idx) begin
        n_cmp++;
        if (dout !== prev) begin n_mis++; $display("FAIL stall_dout: got %h want %h", dout, prev); end
        stall(stall_cyc, 1'b1);
        idle_inputs(); laf_state = 1'b1; pkt_valid = 1'b1; tick();
        n_cmp++;
        if (dout !== pay[i]) begin n_mis++; $display("FAIL laf_dout: got %h want %h", dout, pay[i]); end
      end else begin
        n_cmp++;
        if (dout !== pay[i]) begin n_mis++; $display("FAIL ld_dout[%0d]: got %h want %h", i, dout, pay[i]); end
      end
      prev = pay[i];
    end
    idle_inputs(); ld_state = 1'b1; pkt_valid = 1'b0; data_in = par; fifo_full = full_par; tick();
    if (full_par) begin
      n_cmp++;
      if (parity_done !== 1'b0 || low_pkt_valid !== 1'b1 || dout !== prev) begin
        n_mis++;
        $display("FAIL par_deferred: parity_done=%b low_pkt_valid=%b dout=%h want 0 1 %h",
                 parity_done, low_pkt_valid, dout, prev);
      end
      stall(stall_cyc, 1'b0);
      n_cmp++;
      if (parity_done !== 1'b0) begin n_mis++; $display("FAIL par_stall: parity_done=%b want 0", parity_done); end
      idle_inputs(); laf_state = 1'b1; tick();
    end
    n_cmp++;
    if (dout !== par || parity_done !== 1'b1 || low_pkt_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL par_done: dout=%h parity_done=%b low_pkt_valid=%b want %h 1 1",
               dout, parity_done, low_pkt_valid, par);
    end
    idle_inputs(); rst_int_reg = 1'b1; tick();
    n_cmp++;
    if (low_pkt_valid !== 1'b0 || err !== exp_err) begin
      n_mis++;
      $display("FAIL check_parity: low_pkt_valid=%b err=%b want 0 %b", low_pkt_valid, err, exp_err);
    end
`ifdef ROUTER_REG_LEN_CHECK_EN
    n_cmp++;
    if (len_err !== exp_len_err) begin n_mis++; $display("FAIL len_err: got %b want %b", len_err, exp_len_err); end
`endif
    idle_inputs(); tick();
    n_cmp++;
    if (err !== exp_err || parity_done !== 1'b1) begin
      n_mis++; $display("FAIL err_hold: err=%b parity_done=%b want %b 1", err, parity_done, exp_err);
    end
  endtask

  function automatic logic [7:0] model_parity(input logic [7:0] h, input int n);
    logic [7:0] p = h;
    for (int i = 0; i < n; i++) p ^= pay[i];
    return p;
  endfunction

  task automatic load_abc();
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (dout !== 8'h00 || parity_done !== 1'b0 || low_pkt_valid !== 1'b0 || err !== 1'b0) begin
      n_mis++;
      $display("FAIL %s: dout=%h parity_done=%b low_pkt_valid=%b err=%b want all 0",
               tag, dout, parity_done, low_pkt_valid, err);
    end
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1'b1; tick(); tick();
    check_all_zero("reset_initial");
`ifdef ROUTER_REG_LEN_CHECK_EN
    n_cmp++;
    if (len_err !== 1'b0) begin n_mis++; $display("FAIL reset_len_err: got %b want 0", len_err); end
`endif
    reset = 1'b0;
    idle_inputs(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D; tick();
    idle_inputs(); lfd_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D; tick();
    idle_inputs(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'hA1; tick();
    idle_inputs(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'hB2; tick();
    // Reset while ld_state would otherwise capture a parity byte
    idle_inputs(); reset = 1'b1; ld_state = 1'b1; pkt_valid = 1'b0; data_in = 8'h5A; tick();
    check_all_zero("reset_mid_payload");
    reset = 1'b0;
    idle_inputs(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'hA7; tick();
    idle_inputs(); lfd_state = 1'b1; tick();
    n_cmp++;
    if (dout !== 8'h00) begin n_mis++; $display("FAIL reset_hdr: dout=%h want 00", dout); end
    load_abc();
    send_packet(8'h0D, 3, 8'hDD, -1, 1'b0, 1, 1'b0, 1'b0);
    send_packet(8'h0D, 3, 8'hDC, -1, 1'b0, 1, 1'b1, 1'b0);
    idle_inputs(); reset = 1'b1; tick();
    check_all_zero("reset_after_err");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    load_abc();
    send_packet(8'h0D, 3, 8'hDD, -1, 1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_parity_error();
    load_abc();
    send_packet(8'h0D, 3, 8'hDC, -1, 1'b0, 1, 1'b1, 1'b0);
    send_packet(8'h0D, 3, 8'hDD, -1, 1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_full_payload();
    load_abc();
    send_packet(8'h0D, 3, 8'hDD, 1, 1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_full_parity();
    load_abc();
    send_packet(8'h0D, 3, 8'hDD, -1, 1'b1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_invalid_addr();
    logic [7:0] keep;
    keep = last_hdr;
    idle_inputs(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h17; tick();
    idle_inputs(); lfd_state = 1'b1; tick();
    n_cmp++;
    if (dout !== keep) begin n_mis++; $display("FAIL invalid_addr_hdr: dout=%h want %h", dout, keep); end
  endtask

`ifdef ROUTER_REG_LEN_CHECK_EN
  task automatic test_len_check();
    load_abc();
    send_packet(8'h11, 3, model_parity(8'h11, 3), -1, 1'b0, 1, 1'b0, 1'b1);
    send_packet(8'h0D, 3, 8'hDD, 2, 1'b0, 1, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      int         n;
      int         fidx;
      bit         fpar;
      bit         corrupt;
      int         sc;
      logic [7:0] h;
      logic [7:0] p;
      n = int'($urandom_range(12, 1));
      h[1:0] = 2'($urandom_range(2, 0));
      h[7:2] = ($urandom_range(1, 0) == 1) ? 6'(n) : 6'($urandom_range(15, 1));
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      fidx    = ($urandom_range(1, 0) == 1) ? int'($urandom_range(n - 1, 0)) : -1;
      fpar    = ($urandom_range(2, 0) == 0);
      corrupt = ($urandom_range(1, 0) == 1);
      sc      = int'($urandom_range(3, 1));
      p = model_parity(h, n);
      if (corrupt) p = p ^ (8'h01 << $urandom_range(7, 0));
      send_packet(h, n, p, fidx, fpar, sc, corrupt, (int'(h[7:2]) != n));
      repeat ($urandom_range(2, 0)) begin idle_inputs(); tick(); end
    end
  endtask

  initial begin
    idle_inputs();
    reset    = 1'b1;
    last_hdr = 8'h00;
    test_reset();
    test_basic();
    test_parity_error();
    test_full_payload();
    test_full_parity();
    test_invalid_addr();
`ifdef ROUTER_REG_LEN_CHECK_EN
    test_len_check();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
